// File: rtl/arm_pkg.sv
// Shared encodings for the ARM pipeline execute stage: ALU opcodes,
// shifter types and forwarding-mux selects.
package arm_pkg;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    FWD_ID  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ARM ALU producing the result and the NZCV flags; flags not
// touched by an opcode are passed through from i_flags.
module alu
  import arm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_cmd,
  input  logic            i_cin,
  input  logic [3:0]      i_flags,
  output logic [XLEN-1:0] o_res,
  output logic [3:0]      o_nzcv
);

  logic [XLEN:0] w_sum;
  logic          w_ci;
  logic          w_c;
  logic          w_v;
  logic          w_known;

  always_comb begin
    w_sum   = '0;
    w_ci    = 1'b0;
    w_c     = i_flags[1];
    w_v     = i_flags[0];
    w_known = 1'b1;
    o_res   = '0;
    case (i_cmd)
      EXE_MOV: o_res = i_b;
      EXE_MVN: o_res = ~i_b;
      EXE_ADD, EXE_ADC: begin
        w_ci  = (i_cmd == EXE_ADC) ? i_cin : 1'b0;
        w_sum = {1'b0, i_a} + {1'b0, i_b} + {{XLEN{1'b0}}, w_ci};
        o_res = w_sum[XLEN-1:0];
        w_c   = w_sum[XLEN];
        w_v   = (i_a[XLEN-1] == i_b[XLEN-1]) && (o_res[XLEN-1] != i_a[XLEN-1]);
      end
      // Subtraction as A + ~B + carry, so the carry-out is NOT borrow.
      EXE_SUB, EXE_SBC: begin
        w_ci  = (i_cmd == EXE_SBC) ? i_cin : 1'b1;
        w_sum = {1'b0, i_a} + {1'b0, ~i_b} + {{XLEN{1'b0}}, w_ci};
        o_res = w_sum[XLEN-1:0];
        w_c   = w_sum[XLEN];
        w_v   = (i_a[XLEN-1] != i_b[XLEN-1]) && (o_res[XLEN-1] != i_a[XLEN-1]);
      end
      EXE_AND: o_res = i_a & i_b;
      EXE_ORR: o_res = i_a | i_b;
      EXE_EOR: o_res = i_a ^ i_b;
      default: w_known = 1'b0;
    endcase
    o_nzcv = w_known ? {o_res[XLEN-1], (o_res == '0), w_c, w_v} : i_flags;
  end

endmodule

// File: rtl/exe_stage.sv
// ARM pipeline execute stage: forwarding muxes, operand-2 generation, ALU,
// NZCV status register, branch target and the EXE/MEM pipeline register.
module exe_stage
  import arm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            flush,
  input  logic [3:0]      exe_cmd,
  input  logic            wb_en_in,
  input  logic            mem_r_en_in,
  input  logic            mem_w_en_in,
  input  logic            s_in,
  input  logic            b_in,
  input  logic            imm_in,
  input  logic [11:0]     shift_operand,
  input  logic [23:0]     signed_imm_24,
  input  logic [3:0]      dest_in,
  input  logic [XLEN-1:0] val_rn,
  input  logic [XLEN-1:0] val_rm,
  input  logic [XLEN-1:0] pc_in,
  input  logic [1:0]      sel_src1,
  input  logic [1:0]      sel_src2,
  input  logic [XLEN-1:0] mem_fwd,
  input  logic [XLEN-1:0] wb_fwd,
  output logic [XLEN-1:0] alu_res,
  output logic [XLEN-1:0] val_rm_out,
  output logic [3:0]      dest_out,
  output logic            wb_en_out,
  output logic            mem_r_en_out,
  output logic            mem_w_en_out,
  output logic [3:0]      status,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_addr
);

  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_val_rm_fwd;
  logic [XLEN-1:0] w_val2;
  logic [XLEN-1:0] w_alu_res;
  logic [3:0]      w_nzcv;
  logic [4:0]      w_sh_amt;

  logic [XLEN-1:0] r_alu_res;
  logic [XLEN-1:0] r_val_rm;
  logic [3:0]      r_dest;
  logic            r_wb_en;
  logic            r_mem_r_en;
  logic            r_mem_w_en;
  logic [3:0]      r_status;

  function automatic logic [XLEN-1:0] ror(input logic [XLEN-1:0] v, input logic [4:0] amt);
    return (v >> amt) | (v << (XLEN - int'(amt)));
  endfunction

  always_comb begin
    case (fwd_sel_e'(sel_src1))
      FWD_MEM: w_src1 = mem_fwd;
      FWD_WB:  w_src1 = wb_fwd;
      default: w_src1 = val_rn;
    endcase
    case (fwd_sel_e'(sel_src2))
      FWD_MEM: w_val_rm_fwd = mem_fwd;
      FWD_WB:  w_val_rm_fwd = wb_fwd;
      default: w_val_rm_fwd = val_rm;
    endcase
  end

  assign w_sh_amt = shift_operand[11:7];

  always_comb begin
    w_val2 = '0;
    if (mem_r_en_in || mem_w_en_in) begin
      w_val2 = XLEN'(shift_operand);
    end else if (imm_in) begin
      w_val2 = ror(XLEN'(shift_operand[7:0]), {shift_operand[11:8], 1'b0});
    end else begin
      case (shift_e'(shift_operand[6:5]))
        SH_LSL: w_val2 = w_val_rm_fwd << w_sh_amt;
        SH_LSR: w_val2 = w_val_rm_fwd >> w_sh_amt;
        SH_ASR: w_val2 = $signed(w_val_rm_fwd) >>> w_sh_amt;
        SH_ROR: w_val2 = ror(w_val_rm_fwd, w_sh_amt);
        default: w_val2 = w_val_rm_fwd;
      endcase
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .i_a     (w_src1),
    .i_b     (w_val2),
    .i_cmd   (exe_cmd),
    .i_cin   (r_status[1]),
    .i_flags (r_status),
    .o_res   (w_alu_res),
    .o_nzcv  (w_nzcv)
  );

  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{(XLEN-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

  // Flush overrides freeze: a bubble is inserted even while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_res  <= '0;
      r_val_rm   <= '0;
      r_dest     <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_status   <= '0;
    end else begin
      if (flush || !freeze) begin
        r_alu_res  <= w_alu_res;
        r_val_rm   <= w_val_rm_fwd;
        r_dest     <= dest_in;
        r_wb_en    <= wb_en_in    && !flush;
        r_mem_r_en <= mem_r_en_in && !flush;
        r_mem_w_en <= mem_w_en_in && !flush;
      end
      if (s_in && !freeze && !flush) begin
        r_status <= w_nzcv;
      end
    end
  end

  assign alu_res      = r_alu_res;
  assign val_rm_out   = r_val_rm;
  assign dest_out     = r_dest;
  assign wb_en_out    = r_wb_en;
  assign mem_r_en_out = r_mem_r_en;
  assign mem_w_en_out = r_mem_w_en;
  assign status       = r_status;

endmodule

// File: tb/tb_exe_stage.sv
// Directed plus randomized bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic [3:0]  exe_cmd;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm_in;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest_in;
  logic [31:0] val_rn, val_rm, pc_in, mem_fwd, wb_fwd;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] alu_res, val_rm_out, branch_addr;
  logic [3:0]  dest_out, status;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken;

  always #5 clk = ~clk;

  exe_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .exe_cmd(exe_cmd),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .b_in(b_in), .imm_in(imm_in), .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24), .dest_in(dest_in), .val_rn(val_rn), .val_rm(val_rm),
    .pc_in(pc_in), .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd(mem_fwd),
    .wb_fwd(wb_fwd), .alu_res(alu_res), .val_rm_out(val_rm_out), .dest_out(dest_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .status(status), .branch_taken(branch_taken), .branch_addr(branch_addr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_alu = '0, m_rm = '0;
  logic [3:0]  m_dest = '0, m_status = '0;
  logic        m_wb = 1'b0, m_mr = 1'b0, m_mw = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] id_v);
    if (sel == 2'd1) return mem_fwd;
    if (sel == 2'd2) return wb_fwd;
    return id_v;
  endfunction

  function automatic logic [31:0] ref_val2(input logic [31:0] rm);
    logic [63:0] dbl;
    int          amt;
    int signed   srm;
    if (mem_r_en_in || mem_w_en_in) return {20'b0, shift_operand};
    if (imm_in) begin
      dbl = {24'b0, shift_operand[7:0], 24'b0, shift_operand[7:0]} >> (2 * shift_operand[11:8]);
      return dbl[31:0];
    end
    amt = int'(shift_operand[11:7]);
    srm = rm;
    dbl = {rm, rm} >> amt;
    case (shift_operand[6:5])
      2'b00:   return rm << amt;
      2'b01:   return rm >> amt;
      2'b10:   return srm >>> amt;
      default: return dbl[31:0];
    endcase
  endfunction

  task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] st, output logic [31:0] res, output logic [3:0] fl);
    longint unsigned ua, ub, s;
    longint          sa, sb, ss;
    logic            c, v;
    int              k;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = st[1]; v = st[0];
    case (cmd)
      4'd1: res = b;
      4'd9: res = ~b;
      4'd2, 4'd3: begin
        k  = (cmd == 4'd3) ? int'(st[1]) : 0;
        s  = ua + ub + longint'(k);
        res = s[31:0];
        c  = (s > 64'hFFFF_FFFF);
        ss = sa + sb + longint'(k);
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        k  = (cmd == 4'd5) ? int'(!st[1]) : 0;
        s  = ua - ub - longint'(k);
        res = s[31:0];
        c  = (ua >= ub + longint'(k));
        ss = sa - sb - longint'(k);
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd6: res = a & b;
      4'd7: res = a | b;
      4'd8: res = a ^ b;
      default: begin
        res = '0;
        fl  = st;
        return;
      end
    endcase
    fl = {res[31], res == 32'd0, c, v};
  endtask

  task automatic step();
    logic [31:0] a, rm, b, res;
    logic [3:0]  fl;
    #1;
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, b_in});
    chk("branch_addr", branch_addr, pc_in + 32'(int'($signed(signed_imm_24)) * 4));
    a  = ref_fwd(sel_src1, val_rn);
    rm = ref_fwd(sel_src2, val_rm);
    b  = ref_val2(rm);
    ref_alu(exe_cmd, a, b, m_status, res, fl);
    @(posedge clk);
    if (rst) begin
      m_alu = '0; m_rm = '0; m_dest = '0; m_wb = 0; m_mr = 0; m_mw = 0; m_status = '0;
    end else begin
      if (flush || !freeze) begin
        m_alu = res; m_rm = rm; m_dest = dest_in;
        m_wb = wb_en_in & ~flush; m_mr = mem_r_en_in & ~flush; m_mw = mem_w_en_in & ~flush;
      end
      if (s_in && !freeze && !flush) m_status = fl;
    end
    #1;
    chk("alu_res", alu_res, m_alu);
    chk("val_rm_out", val_rm_out, m_rm);
    chk("dest_out", {28'b0, dest_out}, {28'b0, m_dest});
    chk("ctrl_out", {29'b0, wb_en_out, mem_r_en_out, mem_w_en_out}, {29'b0, m_wb, m_mr, m_mw});
    chk("status", {28'b0, status}, {28'b0, m_status});
  endtask

  task automatic idle();
    rst = 0; freeze = 0; flush = 0; exe_cmd = '0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; s_in = 0; b_in = 0; imm_in = 0;
    shift_operand = '0; signed_imm_24 = '0; dest_in = '0;
    val_rn = '0; val_rm = '0; pc_in = '0; mem_fwd = '0; wb_fwd = '0;
    sel_src1 = '0; sel_src2 = '0;
  endtask

  initial begin
    idle();
    val_rn = 32'hDEAD_BEEF; wb_en_in = 1; rst = 1;
    step();
    chk("reset_alu", alu_res, 32'd0);
    chk("reset_status", {28'b0, status}, 32'd0);

    idle(); exe_cmd = 4'd2; val_rn = 5; val_rm = 7; s_in = 1; wb_en_in = 1; dest_in = 4'd1;
    step();
    chk("add_res", alu_res, 32'd12);
    chk("add_status", {28'b0, status}, 32'h0);

    idle(); exe_cmd = 4'd4; sel_src1 = 2'd1; sel_src2 = 2'd2; mem_fwd = 3; wb_fwd = 5;
    val_rn = 32'h1234; val_rm = 32'h99; s_in = 1;
    step();
    chk("sub_res", alu_res, 32'hFFFF_FFFE);
    chk("sub_status", {28'b0, status}, 32'h8);
    chk("sub_rm_out", val_rm_out, 32'd5);

    idle(); exe_cmd = 4'd1; imm_in = 1; shift_operand = 12'h2FF;
    step();
    chk("mov_imm", alu_res, 32'hF000_000F);

    idle(); exe_cmd = 4'd2; val_rn = 32'h7FFF_FFFF; val_rm = 1; s_in = 1;
    step();
    chk("ovf_status", {28'b0, status}, 32'h9);
    idle(); exe_cmd = 4'd3; s_in = 1;
    step();
    chk("adc_res", alu_res, 32'd0);

    idle(); exe_cmd = 4'd2; val_rn = 32'h100; shift_operand = 12'h00C;
    mem_r_en_in = 1; wb_en_in = 1; dest_in = 4'd3; freeze = 1;
    step();
    step();
    chk("frz_alu_hold", alu_res, 32'd0);
    chk("frz_mr_hold", {31'b0, mem_r_en_out}, 32'd0);
    freeze = 0;
    step();
    chk("ldr_res", alu_res, 32'h10C);
    chk("ldr_mr", {31'b0, mem_r_en_out}, 32'd1);

    idle(); b_in = 1; pc_in = 32'h20; signed_imm_24 = 24'hFFFFFE; flush = 1; s_in = 1;
    wb_en_in = 1; exe_cmd = 4'd4; val_rn = 1; val_rm = 1;
    #1;
    chk("br_addr_const", branch_addr, 32'h18);
    chk("br_taken_const", {31'b0, branch_taken}, 32'd1);
    step();
    chk("flush_wb", {31'b0, wb_en_out}, 32'd0);
    chk("flush_status", {28'b0, status}, 32'h4);

    idle(); freeze = 1; flush = 1; wb_en_in = 1; mem_w_en_in = 1; exe_cmd = 4'd7; val_rn = 32'hF0;
    step();
    idle(); freeze = 1; rst = 1; wb_en_in = 1;
    step();
    chk("rst_in_stall", {31'b0, wb_en_out}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      idle();
      rst           = ($urandom_range(0, 40) == 0);
      freeze        = ($urandom_range(0, 6) == 0);
      flush         = ($urandom_range(0, 6) == 0);
      exe_cmd       = 4'($urandom_range(0, 15));
      wb_en_in      = 1'($urandom);
      mem_r_en_in   = ($urandom_range(0, 5) == 0);
      mem_w_en_in   = ($urandom_range(0, 5) == 0);
      s_in          = 1'($urandom);
      b_in          = 1'($urandom);
      imm_in        = 1'($urandom);
      shift_operand = 12'($urandom);
      signed_imm_24 = 24'($urandom);
      dest_in       = 4'($urandom);
      val_rn        = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF + 32'($urandom_range(0, 2)) : $urandom;
      val_rm        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      pc_in         = $urandom;
      mem_fwd       = $urandom;
      wb_fwd        = $urandom;
      sel_src1      = 2'($urandom);
      sel_src2      = 2'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
